// File: rtl/approx_pkg.sv
// Shared types and helpers for the approximate-multiplier scheduler.
// approx_norm reduces an 8-bit operand to a 4-bit mantissa plus a right-shift amount.
package approx_pkg;

   localparam int DATA_W = 8;
   localparam int PROD_W = 16;

   // One pair of multiplier operands as captured by the operand stage.
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } op_t;

   typedef logic [PROD_W-1:0] prod_t;

   // Returns {shift[2:0], mantissa[3:0]}.
   // The shift is (leading-one position - 3) when the upper nibble is nonzero, else 0.
   function automatic logic [6:0] approx_norm(input logic [DATA_W-1:0] x);
      logic [2:0]        sh;
      logic [DATA_W-1:0] t;
      if (x[7])      sh = 3'd4;
      else if (x[6]) sh = 3'd3;
      else if (x[5]) sh = 3'd2;
      else if (x[4]) sh = 3'd1;
      else           sh = 3'd0;
      t = x >> sh;
      return {sh, t[3:0]};
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at i_ptr and wraps modulo NREQ.
// Grants at most one requester, and only while i_en is high.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   input  logic            i_en,
   output logic [NREQ-1:0] o_grant
);

   logic [IDW-1:0] w_idx;
   logic           w_found;

   // Walk the requesters in priority order and grant the first one with a pending request.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = IDW'((int'(i_ptr) + k) % NREQ);
         if (i_en && !w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/unsignedApproxMult.sv
// Combinational 8x8 unsigned approximate multiplier.
// Both operands are normalised to 4-bit mantissas. The mantissas are multiplied and the
// product is shifted back by the sum of the two shifts. There is no rounding or correction.
module unsignedApproxMult
   import approx_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output prod_t             o_y
);

   logic [6:0] w_na;
   logic [6:0] w_nb;
   logic [7:0] w_mp;
   logic [3:0] w_sh;

   assign w_na = approx_norm(i_a);
   assign w_nb = approx_norm(i_b);
   assign w_mp = {4'b0, w_na[3:0]} * {4'b0, w_nb[3:0]};
   assign w_sh = {1'b0, w_na[6:4]} + {1'b0, w_nb[6:4]};
   // The largest result is 225 << 8, so the product always fits in 16 bits.
   assign o_y  = {8'b0, w_mp} << w_sh;

endmodule

// File: rtl/approx_mult_scheduler.sv
// Shares one approximate multiplier between NREQ requesters through a 2-stage pipeline
// (operand register S1, then product register S2) with round-robin arbitration.
//
// Handshake: a transfer occurs on a port in a cycle where valid and ready are both high
// at the rising edge. Valid must not depend on ready. req_ready is the combinational
// grant, and at most one bit of it is high. rsp_id and rsp_y stay stable while
// rsp_valid is high and rsp_ready is low.
module approx_mult_scheduler
   import approx_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ),
   parameter int CNT_W = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NREQ-1:0]      i_req_valid,
   output logic [NREQ-1:0]      o_req_ready,
   input  logic [NREQ*8-1:0]    i_req_a,
   input  logic [NREQ*8-1:0]    i_req_b,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [IDW-1:0]       o_rsp_id,
   output logic [PROD_W-1:0]    o_rsp_y,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_ops_cnt
);

   logic             r_s1_vld;
   logic [IDW-1:0]   r_s1_id;
   op_t              r_s1_op;
   logic             r_s2_vld;
   logic [IDW-1:0]   r_s2_id;
   prod_t            r_s2_y;
   logic [IDW-1:0]   r_rr_ptr;
   logic [CNT_W-1:0] r_ops_cnt;

   logic             w_s1_adv;
   logic             w_s2_adv;
   logic [NREQ-1:0]  w_grant;
   logic             w_grant_any;
   logic [IDW-1:0]   w_grant_id;
   logic [IDW-1:0]   w_next_ptr;
   op_t              w_sel_op;
   prod_t            w_prod;

   assign w_s2_adv = !r_s2_vld || i_rsp_ready;
   assign w_s1_adv = !r_s1_vld || w_s2_adv;

   // No grant while reset is held, so req_ready reads zero during reset.
   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .i_req   (i_req_valid),
      .i_ptr   (r_rr_ptr),
      .i_en    (w_s1_adv && !i_rst),
      .o_grant (w_grant)
   );

   // Encode the one-hot grant and select the granted requester's operands.
   always_comb begin
      w_grant_id = '0;
      w_sel_op   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_grant_id = IDW'(i);
            w_sel_op.a = i_req_a[DATA_W*i +: DATA_W];
            w_sel_op.b = i_req_b[DATA_W*i +: DATA_W];
         end
      end
   end

   assign w_grant_any = |w_grant;
   assign w_next_ptr  = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);

   // Operand stage: capture the granted request. When idle, keep the operands so the
   // multiplier inputs do not toggle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_vld <= 1'b0;
         r_s1_id  <= '0;
         r_s1_op  <= '0;
         r_rr_ptr <= '0;
      end else if (w_s1_adv) begin
         if (w_grant_any) begin
            r_s1_vld <= 1'b1;
            r_s1_id  <= w_grant_id;
            r_s1_op  <= w_sel_op;
            r_rr_ptr <= w_next_ptr;
         end else begin
            r_s1_vld <= 1'b0;
         end
      end
   end

   unsignedApproxMult u_mult (
      .i_a (r_s1_op.a),
      .i_b (r_s1_op.b),
      .o_y (w_prod)
   );

   // Product stage: load from S1 whenever the consumer side can move.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s2_vld <= 1'b0;
         r_s2_id  <= '0;
         r_s2_y   <= '0;
      end else if (w_s2_adv) begin
         r_s2_vld <= r_s1_vld;
         r_s2_id  <= r_s1_id;
         r_s2_y   <= w_prod;
      end
   end

   // Count completed responses; the counter saturates at all-ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ops_cnt <= '0;
      end else if (r_s2_vld && i_rsp_ready && (r_ops_cnt != '1)) begin
         r_ops_cnt <= r_ops_cnt + CNT_W'(1);
      end
   end

   assign o_req_ready = w_grant;
   assign o_rsp_valid = r_s2_vld;
   assign o_rsp_id    = r_s2_id;
   assign o_rsp_y     = r_s2_y;
   assign o_busy      = r_s1_vld || r_s2_vld;
   assign o_ops_cnt   = r_ops_cnt;

endmodule

// File: tb/tb_approx_mult_scheduler.sv
// Directed bench for approx_mult_scheduler. Operand/product pairs come from a hand-computed
// table, followed by round-robin, backpressure, mid-flight reset and counter
// saturation sequences.
module tb_approx_mult_scheduler;

   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int CNT_W = 16;
   localparam int NV    = 10;

   typedef struct {
      logic [1:0]  id;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] y;
   } vec_t;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // main DUT signals
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*8-1:0] req_a;
   logic [NREQ*8-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [15:0]       rsp_y;
   logic              busy;
   logic [CNT_W-1:0]  ops_cnt;

   // narrow-counter DUT signals
   logic [NREQ-1:0]   sat_valid;
   logic [NREQ-1:0]   sat_ready;
   logic [NREQ*8-1:0] sat_a;
   logic [NREQ*8-1:0] sat_b;
   logic              sat_rsp_valid;
   logic              sat_rsp_ready;
   logic [IDW-1:0]    sat_rsp_id;
   logic [15:0]       sat_rsp_y;
   logic              sat_busy;
   logic [1:0]        sat_cnt;

   approx_mult_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNT_W(CNT_W)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_id    (rsp_id),
      .o_rsp_y     (rsp_y),
      .o_busy      (busy),
      .o_ops_cnt   (ops_cnt)
   );

   approx_mult_scheduler #(.NREQ(NREQ), .IDW(IDW), .CNT_W(2)) dut_sat (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (sat_valid),
      .o_req_ready (sat_ready),
      .i_req_a     (sat_a),
      .i_req_b     (sat_b),
      .o_rsp_valid (sat_rsp_valid),
      .i_rsp_ready (sat_rsp_ready),
      .o_rsp_id    (sat_rsp_id),
      .o_rsp_y     (sat_rsp_y),
      .o_busy      (sat_busy),
      .o_ops_cnt   (sat_cnt)
   );

   // scoreboard
   int          n_cmp = 0;
   int          n_err = 0;
   int          n_acc = 0;
   int          n_rsp = 0;
   int          exp_ops = 0;
   logic [17:0] exp_q[$];
   vec_t        tbl[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // One clock of the main DUT with the inputs already driven. The task samples
   // handshakes, scores responses and queues the exact product of accepted requests.
   // Only operands below 16 go through here.
   task automatic cycle_mon(output logic [3:0] rdy_o, output logic vld_o, output logic [15:0] y_o);
      logic [17:0] e;
      logic [15:0] pa;
      logic [15:0] pb;
      #1;
      rdy_o = req_ready;
      vld_o = rsp_valid;
      y_o   = rsp_y;
      if (rsp_valid && rsp_ready) begin
         n_rsp++;
         exp_ops++;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rsp_unexpected: got id %0d y %0d, required no response", rsp_id, rsp_y);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e[17:16]));
            chk("rsp_y", 32'(rsp_y), 32'(e[15:0]));
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && rdy_o[i]) begin
            n_acc++;
            pa = 16'(req_a[8*i +: 8]);
            pb = 16'(req_b[8*i +: 8]);
            exp_q.push_back({2'(i), 16'(pa * pb)});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0]  rdy;
      logic        v;
      logic [15:0] y;
      logic [15:0] held_y;
      int          acc0;
      logic [3:0]  bp_rdy[5];
      logic [1:0]  sat_exp[10];

      tbl[0] = '{2'd0,   8'd9,   8'd7,    16'd63};
      tbl[1] = '{2'd1, 8'd200, 8'd100, 16'd18432};
      tbl[2] = '{2'd2, 8'd255, 8'd255, 16'd57600};
      tbl[3] = '{2'd3,  8'd15,  8'd15,   16'd225};
      tbl[4] = '{2'd0,  8'd16,  8'd16,   16'd256};
      tbl[5] = '{2'd1,   8'd0, 8'd123,     16'd0};
      tbl[6] = '{2'd2, 8'd128,   8'd3,   16'd384};
      tbl[7] = '{2'd3, 8'd100,  8'd10,   16'd960};
      tbl[8] = '{2'd0,  8'd31,  8'd31,   16'd900};
      tbl[9] = '{2'd1,   8'd1, 8'd255,   16'd240};
      bp_rdy  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
      sat_exp = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

      // reset with every requester asking
      rst           = 1'b1;
      req_valid     = 4'hF;
      req_a         = 32'h0A0B0C0D;
      req_b         = 32'h01020304;
      rsp_ready     = 1'b1;
      sat_valid     = '0;
      sat_a         = 32'h03030303;
      sat_b         = 32'h03030303;
      sat_rsp_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_y", 32'(rsp_y), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ops_cnt", 32'(ops_cnt), 0);
      req_valid = '0;
      rst       = 1'b0;
      @(posedge clk); #1;

      // table: one requester at a time, response two edges after presentation
      for (int t = 0; t < NV; t++) begin
         req_a = '0;
         req_b = '0;
         req_a[8*int'(tbl[t].id) +: 8] = tbl[t].a;
         req_b[8*int'(tbl[t].id) +: 8] = tbl[t].b;
         req_valid = 4'(1) << tbl[t].id;
         #1;
         chk("tbl_req_ready", 32'(req_ready), 32'(4'(1) << tbl[t].id));
         @(posedge clk); #1;
         req_valid = '0;
         chk("tbl_latency_not_yet", 32'(rsp_valid), 0);
         @(posedge clk); #1;
         chk("tbl_rsp_valid", 32'(rsp_valid), 1);
         chk("tbl_rsp_id", 32'(rsp_id), 32'(tbl[t].id));
         chk("tbl_rsp_y", 32'(rsp_y), 32'(tbl[t].y));
      end
      @(posedge clk); #1;
      chk("tbl_ops_cnt", 32'(ops_cnt), NV);
      chk("tbl_idle_busy", 32'(busy), 0);

      // fresh pointer, then all four requesters for 8 cycles
      rst = 1'b1;
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_ops = 0;
      n_rsp   = 0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[8*i +: 8] = 8'(i + 2);
         req_b[8*i +: 8] = 8'(i + 5);
      end
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      for (int c = 0; c < 8; c++) begin
         cycle_mon(rdy, v, y);
         chk("rr_grant", 32'(rdy), 32'(4'(1) << (c % 4)));
      end
      req_valid = '0;
      for (int c = 0; c < 3; c++) cycle_mon(rdy, v, y);
      chk("rr_rsp_count", n_rsp, 8);
      chk("rr_queue_empty", exp_q.size(), 0);

      // backpressure: consumer stalls for 5 cycles while all request
      acc0      = n_acc;
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      held_y    = 16'd10;
      for (int c = 0; c < 5; c++) begin
         cycle_mon(rdy, v, y);
         chk("bp_req_ready", 32'(rdy), 32'(bp_rdy[c]));
         if (c >= 2) begin
            chk("bp_rsp_valid", 32'(v), 1);
            chk("bp_hold_y", 32'(y), 32'(held_y));
         end
      end
      chk("bp_accepts", n_acc - acc0, 2);
      chk("bp_busy", 32'(busy), 1);
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 3; c++) cycle_mon(rdy, v, y);
      chk("bp_queue_empty", exp_q.size(), 0);
      chk("bp_ops_cnt", 32'(ops_cnt), 32'(exp_ops));

      // reset with two entries in flight
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      cycle_mon(rdy, v, y);
      cycle_mon(rdy, v, y);
      req_valid = '0;
      cycle_mon(rdy, v, y);
      chk("inflight_valid", 32'(v), 1);
      chk("inflight_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_rsp_y", 32'(rsp_y), 0);
      chk("midrst_ops_cnt", 32'(ops_cnt), 0);
      exp_q.delete();
      exp_ops = 0;
      @(posedge clk); #1;
      rst       = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle_mon(rdy, v, y);
         chk("no_stale_rsp", 32'(v), 0);
      end
      chk("post_rst_ops_cnt", 32'(ops_cnt), 0);

      // saturation on a 2-bit counter: 1, 2, then three more completions stay at 3
      sat_valid = 4'hF;
      for (int c = 0; c < 10; c++) begin
         if (c == 5) sat_valid = '0;
         @(posedge clk); #1;
         chk("sat_ops_cnt", 32'(sat_cnt), 32'(sat_exp[c]));
      end
      chk("sat_idle", 32'(sat_busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
